register_file_sweep: RTL and testbench
======================================

// Module: register_file_sweep
// PURPOSE
//  Parametrised general-purpose register file for the single-cycle datapath. It
//  generalises the 16x32 file with: configurable width and depth, posedge
//  registered reads with write-to-read bypass, a dedicated PC register, and a
//  clear-sweep engine that zeroes the GPRs one per cycle on request.
// PARAMETERS
//  DATA_W  32  register width in bits
//  ADDR_W  4   address width; NREGS = 2**ADDR_W; PC_IDX = NREGS-1 (PC register)
// PORTS
//  clk      in   1       clock; all state updates on posedge clk
//  rst      in   1       synchronous, active-high reset
//  A1       in   ADDR_W  read address, port 1
//  A2       in   ADDR_W  read address, port 2
//  A3       in   ADDR_W  write address
//  WD3      in   DATA_W  write data
//  WE3      in   1       write enable
//  R15      in   DATA_W  next PC value, loaded into PC_IDX every cycle
//  clr_req  in   1       start clear sweep (level-sampled; edge not required)
//  RD1      out  DATA_W  read data, port 1 (1-cycle latency)
//  RD2      out  DATA_W  read data, port 2 (1-cycle latency)
//  busy     out  1       clear sweep in progress
//  clr_done out  1       one-cycle pulse in the cycle after the last GPR clears
// BEHAVIOUR
//  Reset (rst=1 at posedge): all NREGS registers <= 0; RD1, RD2 <= 0;
//   busy=0, clr_done=0, sweep counter=0. rst overrides every other input.
//  FSM: IDLE, SWEEP.
//   IDLE: clr_req=1 -> SWEEP, counter <= 0. busy=0.
//   SWEEP: each cycle reg[counter] <= 0, counter++. busy=1.
//    counter==PC_IDX-1 -> IDLE; clr_done=1 in the following cycle only.
//    clr_req is ignored while in SWEEP (no restart, no queueing).
//   Sweep length = NREGS-1 cycles (16 regs -> 15 cycles busy).
//  Writes: if WE3 && !busy && A3!=PC_IDX, reg[A3] <= WD3 at posedge.
//   WE3 while busy is dropped (no effect, no later replay).
//   WE3 to PC_IDX is dropped; PC_IDX is loaded from R15 every non-reset cycle,
//   including during SWEEP. The sweep never touches PC_IDX.
//  Reads: at posedge, RDn <= value of reg[An] as seen after this edge's write,
//   i.e. bypass: if the write above is accepted and A3==An, RDn <= WD3.
//   A read of PC_IDX returns the currently stored PC register (the R15 value
//   sampled at the previous edge), not the R15 input of the current cycle.
//   If An==counter during SWEEP, RDn <= 0 (bypass of the sweep clear).
//   Both ports may address the same register; both return the same value.
//  Outputs hold their value between edges; there are no combinational paths
//   from inputs to RD1/RD2.
//  Reset mid-sweep: returns to IDLE immediately; no clr_done pulse.
//  Widths: all data paths are DATA_W; no sign extension or truncation.
// TESTING
//  1 rst=1 for 2 cycles, then read all regs -> every RDn=0; busy=0, clr_done=0.
//  2 WE3=1, A3=5, WD3=32'hDEADBEEF, A1=5 in the same cycle -> RD1=DEADBEEF after
//    that edge (bypass); the next cycle with A2=5 -> RD2=DEADBEEF.
//  3 WE3=1, A3=15, WD3=32'h1234, R15=32'h40 -> read A1=15 next cycle gives
//    32'h40; the write is dropped.
//  4 Fill r0..r14 with nonzero data, pulse clr_req -> busy=1 for exactly 15
//    cycles, clr_done pulses once, r0..r14 read 0, r15 tracks R15.
//  5 During the sweep, WE3=1, A3=3, WD3=32'hAA -> dropped; r3 reads 0 after the
//    sweep; clr_req again mid-sweep -> the sweep length is unchanged.
//  6 Assert rst at sweep cycle 7 -> busy=0 next cycle, all regs 0, no clr_done.

Source files
------------

// File: rtl/register_file_sweep.sv
// register_file_sweep: parametrised GPR file with registered reads, write-to-read
// bypass, a dedicated PC register loaded every cycle, and a one-register-per-cycle
// clear-sweep engine over the GPRs.
module register_file_sweep #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] A1,
   input  logic [ADDR_W-1:0] A2,
   input  logic [ADDR_W-1:0] A3,
   input  logic [DATA_W-1:0] WD3,
   input  logic              WE3,
   input  logic [DATA_W-1:0] R15,
   input  logic              clr_req,
   output logic [DATA_W-1:0] RD1,
   output logic [DATA_W-1:0] RD2,
   output logic              busy,
   output logic              clr_done
);

   localparam int unsigned       NREGS    = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] PC_IDX   = ADDR_W'(NREGS - 1);
   localparam logic [ADDR_W-1:0] LAST_GPR = ADDR_W'(NREGS - 2);

   typedef enum logic [0:0] {IDLE, SWEEP} state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_cnt;
   logic              r_busy;
   logic              r_clr_done;
   logic [DATA_W-1:0] r_regs [NREGS];
   logic [DATA_W-1:0] r_rd1;
   logic [DATA_W-1:0] r_rd2;

   logic              w_sweeping;
   logic              w_wr_ok;
   logic [DATA_W-1:0] w_rd1_next;
   logic [DATA_W-1:0] w_rd2_next;

   assign w_sweeping = (r_state == SWEEP);
   assign w_wr_ok    = WE3 && !w_sweeping && (A3 != PC_IDX);

   // Sweep sequencer: counter walks r0..r(NREGS-2), done pulses after the last clear
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_busy     <= 1'b0;
         r_clr_done <= 1'b0;
      end else begin
         r_clr_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (clr_req) begin
                  r_state <= SWEEP;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
               end
            end
            SWEEP: begin
               if (r_cnt == LAST_GPR) begin
                  r_state    <= IDLE;
                  r_cnt      <= '0;
                  r_busy     <= 1'b0;
                  r_clr_done <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Register array: accepted write, sweep clear, and unconditional PC load
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            r_regs[i] <= '0;
         end
      end else begin
         if (w_wr_ok) begin
            r_regs[A3] <= WD3;
         end
         if (w_sweeping) begin
            r_regs[r_cnt] <= '0;
         end
         r_regs[PC_IDX] <= R15;
      end
   end

   // Next read values: PC reads the stored value; GPRs see this edge's clear or write
   always_comb begin
      w_rd1_next = r_regs[A1];
      if (A1 != PC_IDX) begin
         if (w_sweeping && (A1 == r_cnt)) begin
            w_rd1_next = '0;
         end else if (w_wr_ok && (A3 == A1)) begin
            w_rd1_next = WD3;
         end
      end
      w_rd2_next = r_regs[A2];
      if (A2 != PC_IDX) begin
         if (w_sweeping && (A2 == r_cnt)) begin
            w_rd2_next = '0;
         end else if (w_wr_ok && (A3 == A2)) begin
            w_rd2_next = WD3;
         end
      end
   end

   // Registered read ports
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd1 <= '0;
         r_rd2 <= '0;
      end else begin
         r_rd1 <= w_rd1_next;
         r_rd2 <= w_rd2_next;
      end
   end

   assign RD1      = r_rd1;
   assign RD2      = r_rd2;
   assign busy     = r_busy;
   assign clr_done = r_clr_done;

endmodule

// File: tb/tb_register_file_sweep.sv
// tb_register_file_sweep: table-driven vectors, hand-written sweep sequences and
// randomized traffic, all checked against a behavioural model of the register file.
module tb_register_file_sweep;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 4;
   localparam int NREGS  = 16;
   localparam int PC     = 15;

   logic              clk = 1'b0;
   logic              rst;
   logic [ADDR_W-1:0] A1, A2, A3;
   logic [DATA_W-1:0] WD3, R15;
   logic              WE3, clr_req;
   logic [DATA_W-1:0] RD1, RD2;
   logic              busy, clr_done;

   int checks   = 0;
   int failures = 0;

   // model state
   logic [DATA_W-1:0] m_regs [NREGS];
   int                m_sweep = -1;   // next GPR to clear, -1 when idle
   logic [DATA_W-1:0] m_rd1 = '0, m_rd2 = '0;
   logic              m_busy = 1'b0, m_done = 1'b0;

   register_file_sweep #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .A1(A1), .A2(A2), .A3(A3), .WD3(WD3), .WE3(WE3),
      .R15(R15), .clr_req(clr_req), .RD1(RD1), .RD2(RD2), .busy(busy),
      .clr_done(clr_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // one clock edge: predict, advance, compare with model
   task automatic cycle();
      logic [DATA_W-1:0] nregs [NREGS];
      bool_t_dummy();
      if (rst) begin
         foreach (nregs[i]) nregs[i] = '0;
         m_rd1 = '0; m_rd2 = '0; m_sweep = -1; m_done = 1'b0;
      end else begin
         bit sweeping, wr_ok;
         sweeping = (m_sweep >= 0);
         wr_ok    = WE3 && !sweeping && (int'(A3) != PC);
         nregs    = m_regs;
         if (wr_ok) nregs[A3] = WD3;
         if (sweeping) nregs[m_sweep] = '0;
         nregs[PC] = R15;
         m_rd1  = (int'(A1) == PC) ? m_regs[PC] : nregs[A1];
         m_rd2  = (int'(A2) == PC) ? m_regs[PC] : nregs[A2];
         m_done = sweeping && (m_sweep == NREGS - 2);
         if (sweeping) m_sweep = (m_sweep == NREGS - 2) ? -1 : m_sweep + 1;
         else if (clr_req) m_sweep = 0;
      end
      m_busy = (m_sweep >= 0);
      @(posedge clk);
      #1;
      m_regs = nregs;
      chk("model_rd1", RD1, m_rd1);
      chk("model_rd2", RD2, m_rd2);
      chk("model_busy", 32'(busy), 32'(m_busy));
      chk("model_done", 32'(clr_done), 32'(m_done));
   endtask

   task automatic bool_t_dummy();
   endtask

   task automatic idle_inputs();
      rst = 1'b0; WE3 = 1'b0; clr_req = 1'b0; A1 = '0; A2 = '0; A3 = '0; WD3 = '0;
   endtask

   typedef struct {
      logic              rst, we;
      logic [ADDR_W-1:0] a1, a2, a3;
      logic [DATA_W-1:0] wd, r15;
      logic [DATA_W-1:0] e_rd1, e_rd2;
      logic              e_busy, e_done;
   } vec_t;

   vec_t vecs [10];

   task automatic fill_gprs(input logic [31:0] seed);
      for (int i = 0; i < NREGS - 1; i++) begin
         WE3 = 1'b1; A3 = ADDR_W'(i); WD3 = seed + 32'(i) * 32'h1111 + 32'h100;
         cycle();
      end
      WE3 = 1'b0;
   endtask

   initial begin
      foreach (m_regs[i]) m_regs[i] = '0;
      idle_inputs();
      R15 = '0;

      //          rst we  a1 a2 a3 wd            r15    rd1           rd2           busy done
      vecs[0] = '{1, 0,  0, 0, 0, 32'h0,        32'h0,  32'h0,        32'h0,        0,   0};
      vecs[1] = '{1, 0,  0, 0, 0, 32'h0,        32'h0,  32'h0,        32'h0,        0,   0};
      vecs[2] = '{0, 0,  0, 1, 0, 32'h0,        32'h0,  32'h0,        32'h0,        0,   0};
      vecs[3] = '{0, 0, 15,14, 0, 32'h0,        32'h40, 32'h0,        32'h0,        0,   0};
      vecs[4] = '{0, 1,  5, 0, 5, 32'hDEADBEEF, 32'h40, 32'hDEADBEEF, 32'h0,        0,   0};
      vecs[5] = '{0, 0, 15, 5, 0, 32'h0,        32'h40, 32'h40,       32'hDEADBEEF, 0,   0};
      vecs[6] = '{0, 1, 15, 0,15, 32'h1234,     32'h40, 32'h40,       32'h0,        0,   0};
      vecs[7] = '{0, 0, 15,15, 0, 32'h0,        32'h80, 32'h40,       32'h40,       0,   0};
      vecs[8] = '{0, 0, 15, 6, 0, 32'h0,        32'h0,  32'h80,       32'h0,        0,   0};
      vecs[9] = '{0, 0,  5, 5, 0, 32'h0,        32'h0,  32'hDEADBEEF, 32'hDEADBEEF, 0,   0};

      #1;
      for (int v = 0; v < 10; v++) begin
         rst = vecs[v].rst; WE3 = vecs[v].we; A1 = vecs[v].a1; A2 = vecs[v].a2;
         A3 = vecs[v].a3; WD3 = vecs[v].wd; R15 = vecs[v].r15;
         cycle();
         chk($sformatf("vec%0d_rd1", v), RD1, vecs[v].e_rd1);
         chk($sformatf("vec%0d_rd2", v), RD2, vecs[v].e_rd2);
         chk($sformatf("vec%0d_busy", v), 32'(busy), 32'(vecs[v].e_busy));
         chk($sformatf("vec%0d_done", v), 32'(clr_done), 32'(vecs[v].e_done));
      end
      idle_inputs();

      // full sweep: busy for exactly NREGS-1 cycles, one done pulse
      begin
         int nb, nd;
         fill_gprs(32'h5000);
         clr_req = 1'b1; cycle(); clr_req = 1'b0;
         nb = busy ? 1 : 0; nd = 0;
         for (int c = 0; c < 30; c++) begin
            R15 = $urandom;
            cycle();
            if (busy) nb++;
            if (clr_done) nd++;
         end
         chk("sweep_busy_cycles", 32'(nb), 32'd15);
         chk("sweep_done_pulses", 32'(nd), 32'd1);
         for (int i = 0; i < NREGS - 1; i++) begin
            A1 = ADDR_W'(i); A2 = ADDR_W'(i);
            cycle();
            chk($sformatf("swept_r%0d", i), RD1, 32'h0);
         end
         R15 = 32'hCAFE0000; cycle();
         A1 = 4'd15; cycle();
         chk("pc_tracks_r15", RD1, 32'hCAFE0000);
      end

      // write and second clr_req during sweep are both ignored
      begin
         int nb;
         idle_inputs();
         fill_gprs(32'h9000);
         clr_req = 1'b1; cycle(); clr_req = 1'b0;
         nb = 1;
         for (int c = 0; c < 30; c++) begin
            WE3 = (c == 9); A3 = 4'd3; WD3 = 32'hAA;
            clr_req = (c == 5);
            cycle();
            if (busy) nb++;
         end
         idle_inputs();
         chk("resweep_busy_cycles", 32'(nb), 32'd15);
         A1 = 4'd3; cycle();
         chk("dropped_write_r3", RD1, 32'h0);
      end

      // reset at sweep cycle 7 aborts without a done pulse
      begin
         int nd;
         idle_inputs();
         fill_gprs(32'h7000);
         clr_req = 1'b1; cycle(); clr_req = 1'b0;
         for (int c = 0; c < 6; c++) cycle();
         chk("mid_sweep_busy", 32'(busy), 32'd1);
         rst = 1'b1; cycle(); rst = 1'b0;
         chk("abort_busy", 32'(busy), 32'd0);
         nd = clr_done ? 1 : 0;
         for (int c = 0; c < 20; c++) begin
            cycle();
            if (clr_done) nd++;
         end
         chk("abort_no_done", 32'(nd), 32'd0);
         for (int i = 0; i < NREGS - 1; i++) begin
            A2 = ADDR_W'(i); cycle();
            chk($sformatf("abort_r%0d", i), RD2, 32'h0);
         end
      end

      // randomized traffic against the model
      for (int c = 0; c < 600; c++) begin
         rst     = ($urandom_range(0, 79) == 0);
         clr_req = ($urandom_range(0, 24) == 0);
         WE3     = $urandom_range(0, 1);
         A1 = ADDR_W'($urandom); A2 = ADDR_W'($urandom); A3 = ADDR_W'($urandom);
         if ($urandom_range(0, 3) == 0) A1 = A3;
         WD3 = $urandom; R15 = $urandom;
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
